// File: rtl/sort4_pkg.sv
// Shared width default and FSM state encoding for the four-entry sequential sorter.
package sort4_pkg;

    localparam int WIDTH = 4;

    typedef enum logic [2:0] {
        CS01A = 3'd0,
        CS12A = 3'd1,
        CS23  = 3'd2,
        CS01B = 3'd3,
        CS12B = 3'd4,
        CS01C = 3'd5,
        DONE  = 3'd6
    } sort_state_t;

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-and-swap: orders one operand pair as (min, max), unsigned.
module cmp_swap
    import sort4_pkg::*;
#(
    parameter int WIDTH = sort4_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    // Strict greater-than so equal operands keep their original order.
    always_comb begin
        if (a > b) begin
            lo = b;
            hi = a;
        end else begin
            lo = a;
            hi = b;
        end
    end

endmodule

// File: rtl/sort4_fsm.sv
// Sequential four-value ascending sorter: one compare-and-swap per clock through a
// single shared cmp_swap, six steps, then holds the result with done asserted.
module sort4_fsm
    import sort4_pkg::*;
#(
    parameter int WIDTH = sort4_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] s0,
    output logic [WIDTH-1:0] s1,
    output logic [WIDTH-1:0] s2,
    output logic [WIDTH-1:0] s3,
    output logic             done
);

    sort_state_t      state_q, state_d;
    logic [WIDTH-1:0] r_q [4];
    logic [WIDTH-1:0] r_d [4];
    logic             done_q, done_d;

    logic [1:0]       idx_a_s, idx_b_s;
    logic             op_en_s;
    logic [WIDTH-1:0] lo_s, hi_s;

    // Step sequencing: choose the register pair for this step and the next state.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        idx_a_s = 2'd0;
        idx_b_s = 2'd1;
        op_en_s = 1'b0;
        case (state_q)
            CS01A: begin
                idx_a_s = 2'd0; idx_b_s = 2'd1; op_en_s = 1'b1;
                state_d = CS12A;
            end
            CS12A: begin
                idx_a_s = 2'd1; idx_b_s = 2'd2; op_en_s = 1'b1;
                state_d = CS23;
            end
            CS23: begin
                idx_a_s = 2'd2; idx_b_s = 2'd3; op_en_s = 1'b1;
                state_d = CS01B;
            end
            CS01B: begin
                idx_a_s = 2'd0; idx_b_s = 2'd1; op_en_s = 1'b1;
                state_d = CS12B;
            end
            CS12B: begin
                idx_a_s = 2'd1; idx_b_s = 2'd2; op_en_s = 1'b1;
                state_d = CS01C;
            end
            CS01C: begin
                idx_a_s = 2'd0; idx_b_s = 2'd1; op_en_s = 1'b1;
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                done_d = 1'b1;
            end
            // Unused encoding: park in DONE with the registers frozen.
            default: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
        endcase
    end

    cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
        .a  (r_q[idx_a_s]),
        .b  (r_q[idx_b_s]),
        .lo (lo_s),
        .hi (hi_s)
    );

    // Operand write-back of the ordered pair for the active step.
    always_comb begin
        r_d = r_q;
        if (op_en_s) begin
            r_d[idx_a_s] = lo_s;
            r_d[idx_b_s] = hi_s;
        end else begin
            r_d = r_q;
        end
    end

    // State, operand and done registers; a low reset loads fresh operands.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_q[0]  <= x0;
            r_q[1]  <= x1;
            r_q[2]  <= x2;
            r_q[3]  <= x3;
            state_q <= CS01A;
            done_q  <= 1'b0;
        end else begin
            r_q     <= r_d;
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign s0   = r_q[0];
    assign s1   = r_q[1];
    assign s2   = r_q[2];
    assign s3   = r_q[3];
    assign done = done_q;

endmodule

// File: tb/tb_sort4_fsm.sv
// Self-checking bench for sort4_fsm: behavioural per-cycle model plus directed literal cases.
module tb_sort4_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] x0 = 4'd0, x1 = 4'd0, x2 = 4'd0, x3 = 4'd0;
    logic [3:0] s0, s1, s2, s3;
    logic       done;

    int checks = 0;
    int errors = 0;

    sort4_fsm #(.WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .x0    (x0),
        .x1    (x1),
        .x2    (x2),
        .x3    (x3),
        .s0    (s0),
        .s1    (s1),
        .s2    (s2),
        .s3    (s3),
        .done  (done)
    );

    initial forever #5 clock = ~clock;

    // Model state: element k lives in bits [4k+3:4k].
    logic [15:0] mv      = 16'd0;
    logic [15:0] ldv     = 16'd0;
    int          mstep   = 0;
    logic        mdone   = 1'b0;
    logic        started = 1'b0;

    function automatic int pair_i(input int step);
        case (step)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 0;
            4: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] cas(input logic [15:0] v, input int step);
        logic [15:0] r;
        int i, j;
        logic [3:0] a, b;
        r = v;
        i = pair_i(step);
        j = i + 1;
        a = v[4*i +: 4];
        b = v[4*j +: 4];
        if (a > b) begin
            r[4*i +: 4] = b;
            r[4*j +: 4] = a;
        end
        return r;
    endfunction

    function automatic logic [15:0] sorted(input logic [15:0] v);
        int e [4];
        int t;
        for (int k = 0; k < 4; k++) e[k] = int'(v[4*k +: 4]);
        for (int p = 0; p < 4; p++)
            for (int q = 0; q < 3 - p; q++)
                if (e[q] > e[q+1]) begin
                    t = e[q]; e[q] = e[q+1]; e[q+1] = t;
                end
        return {e[3][3:0], e[2][3:0], e[1][3:0], e[0][3:0]};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advances on the same edges as the DUT.
    always @(posedge clock) begin
        if (!reset) begin
            mv      <= {x3, x2, x1, x0};
            ldv     <= {x3, x2, x1, x0};
            mstep   <= 0;
            mdone   <= 1'b0;
            started <= 1'b1;
        end else if (mstep < 6) begin
            mv    <= cas(mv, mstep);
            mstep <= mstep + 1;
            mdone <= (mstep == 5);
        end
    end

    always @(negedge clock) begin
        if (started) begin
            check("model_s", {s3, s2, s1, s0}, mv);
            check("model_done", {15'd0, done}, {15'd0, mdone});
            if (mdone) check("perm_sorted", {s3, s2, s1, s0}, sorted(ldv));
        end
    end

    task automatic load(input logic [3:0] a0, a1, a2, a3);
        @(negedge clock);
        reset = 1'b0;
        x0 = a0; x1 = a1; x2 = a2; x3 = a3;
        @(negedge clock);
        check("load_s", {s3, s2, s1, s0}, {a3, a2, a1, a0});
        check("load_done", {15'd0, done}, 16'd0);
        reset = 1'b1;
    endtask

    task automatic sort_case(input string nm, input logic [3:0] a0, a1, a2, a3,
                             input logic [15:0] exp);
        load(a0, a1, a2, a3);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k < 6) check({nm, "_busy"}, {15'd0, done}, 16'd0);
        end
        check({nm, "_s"}, {s3, s2, s1, s0}, exp);
        check({nm, "_done"}, {15'd0, done}, 16'd1);
    endtask

    function automatic logic [3:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 4'h0;
            1: return 4'hF;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        sort_case("t1", 4'h8, 4'h5, 4'h1, 4'h5, 16'h8551);
        sort_case("t2", 4'h3, 4'h7, 4'h0, 4'h4, 16'h7430);
        sort_case("rev", 4'hF, 4'hA, 4'h5, 4'h0, 16'hFA50);
        sort_case("pre", 4'h0, 4'h1, 4'h2, 4'h3, 16'h3210);
        sort_case("eq", 4'h7, 4'h7, 4'h7, 4'h7, 16'h7777);
        sort_case("ext", 4'hF, 4'h0, 4'hF, 4'h0, 16'hFF00);

        // Reset lands after three sort steps with new operands.
        load(4'hC, 4'h3, 4'hB, 4'h1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        x0 = 4'h2; x1 = 4'h9; x2 = 4'h4; x3 = 4'h1;
        @(negedge clock);
        check("mid_reload", {s3, s2, s1, s0}, 16'h1492);
        check("mid_done", {15'd0, done}, 16'd0);
        reset = 1'b1;
        repeat (6) @(negedge clock);
        check("mid_s", {s3, s2, s1, s0}, 16'h9421);
        check("mid_done1", {15'd0, done}, 16'd1);

        // Inputs churn while parked in DONE.
        repeat (25) begin
            @(negedge clock);
            x0 = rnd_val(); x1 = rnd_val(); x2 = rnd_val(); x3 = rnd_val();
        end
        @(negedge clock);
        check("hold_s", {s3, s2, s1, s0}, 16'h9421);
        check("hold_done", {15'd0, done}, 16'd1);

        // Random loads, random run lengths, inputs changing every cycle.
        repeat (200) begin
            @(negedge clock);
            reset = 1'b0;
            x0 = rnd_val(); x1 = rnd_val(); x2 = rnd_val(); x3 = rnd_val();
            repeat ($urandom_range(1, 2)) @(negedge clock);
            reset = 1'b1;
            repeat ($urandom_range(1, 10)) begin
                x0 = rnd_val(); x1 = rnd_val(); x2 = rnd_val(); x3 = rnd_val();
                @(negedge clock);
            end
        end
        repeat (8) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
